ssd_scan_driver: RTL
====================

// Module: ssd_scan_driver
// PURPOSE
//   Parametrised time-multiplexed seven-segment display driver for NUM_DIGITS hex digits.
//   Divides the system clock internally to the per-digit scan rate; no external slow clock.
//   Adds anti-ghosting dead time, per-digit blanking, decimal points and leading-zero suppression.
//   Inputs are snapshotted once per frame so a digit never changes mid-scan (no tearing).
//   Sits between the datapath debug/value mux and the board anode/cathode pins.
// PARAMETERS
//   NUM_DIGITS  4       digits scanned; 2..8
//   DIV_CNT     100000  clk cycles per digit slot; 100 MHz -> 1 kHz digit rate
//   DEAD_CYC    1000    cycles at slot start with all anodes off; 1 <= DEAD_CYC < DIV_CNT
// PORTS
//   clk         in   1              system clock
//   rst         in   1              asynchronous reset, active-high
//   num         in   4*NUM_DIGITS   digit i displays num[4i+3:4i]; digit 0 is rightmost
//   dp_in       in   NUM_DIGITS     1 = light decimal point of digit i
//   blank       in   NUM_DIGITS     1 = force digit i dark
//   lz_en       in   1              1 = suppress leading zeros
//   an          out  NUM_DIGITS     anode enables, active-low; an[i] drives digit i
//   seg         out  7              cathodes, active-low; seg[0]=a .. seg[6]=g
//   dp          out  1              decimal-point cathode, active-low
//   frame_tick  out  1              one-cycle pulse when a new snapshot is taken
// BEHAVIOUR
//   Reset (async, immediate): an = all 1, seg = 7'h7F, dp = 1, frame_tick = 0;
//     slot_cnt = 0, idx = NUM_DIGITS-1, snapshot registers = 0.
//   slot_cnt counts 0..DIV_CNT-1 and wraps; on wrap idx decrements, NUM_DIGITS-1 after 0.
//   Scan order: most significant digit first (idx NUM_DIGITS-1 down to 0), then repeat.
//   Frame start = cycle with slot_cnt==0 && idx==NUM_DIGITS-1 (incl. first cycle after reset).
//     That cycle registers num, dp_in, blank, lz_en into the snapshot; frame_tick = 1 next cycle.
//     Input changes at any other time are ignored until the next frame start.
//   Outputs are registered: values reflect (slot_cnt, idx, snapshot) of the previous cycle.
//   Per slot, for current idx = i:
//     slot_cnt < DEAD_CYC                      -> an all 1, seg 7'h7F, dp 1 (dead time)
//     slot_cnt >= DEAD_CYC and digit i visible -> an[i] = 0 (others 1), seg = decode(nibble i),
//                                                 dp = ~dp_snap[i]
//     slot_cnt >= DEAD_CYC and digit i hidden  -> an all 1, seg 7'h7F, dp 1
//   Digit i hidden if blank_snap[i], or lz_en_snap && i != 0 && nibbles i..NUM_DIGITS-1 all 0.
//     Digit 0 is never zero-suppressed (value 0 shows a single "0").
//     A suppressed digit keeps its dp dark too (blanked digit is fully dark).
//   Decode (active-low, {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//     8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//   Frame period = NUM_DIGITS*DIV_CNT cycles exactly; no slot skipped when digits hidden.
//   At most one an bit is 0 in any cycle; never two digits lit together.
//   Reset mid-slot: outputs dark immediately; after release scan restarts at frame start.
//   slot_cnt width = $clog2(DIV_CNT); idx width = $clog2(NUM_DIGITS) (min 1).
// STRUCTURE
//   Shared package ssd_pkg: 16-entry active-low segment table, SEG_OFF = 7'h7F.
//   Sub-module ssd_hex_decoder (combinational nibble -> seg, uses ssd_pkg table);
//   prescaler, scan index, snapshot, LZ mask and output registers live in the top.
// TESTING (NUM_DIGITS=4, DIV_CNT=8, DEAD_CYC=2 unless noted)
//   1 Reset held, toggle inputs -> an=4'hF, seg=7'h7F, dp=1, frame_tick=0 throughout.
//   2 num=16'h12AF, lz_en=0 -> an sequence 0111,1011,1101,1110; seg 79,24,08,0E;
//     each lit 6 cycles after 2 dark; frame_tick every 32 cycles.
//   3 num=16'h0030, lz_en=1 -> digits 3,2 dark; digit 1 seg=30, digit 0 seg=40;
//     num=0 -> only digit 0 lit, seg=40.
//   4 dp_in=4'b0100, blank=4'b0001 -> dp=0 only in digit-2 slot; digit 0 slot fully dark.
//   5 Change num mid-frame from 16'h1111 to 16'h2222 -> rest of frame shows 1, next frame 2.
//   6 Async rst pulse mid-slot of digit 1 -> outputs dark same cycle; after release
//     first lit digit is digit 3 at slot_cnt=2; check one-hot-low an with assertion.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared seven-segment constants: active-low segment table ({g..a}) and the all-dark pattern.
package ssd_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the glyph for hex value n; listed F down to 0 so index n lands on glyph n.
  localparam logic [15:0][6:0] SEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TBL[nib_i];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scanner: prescaled digit slots with dead time,
// per-frame input snapshot, blanking, decimal points and leading-zero suppression.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_CNT    = 100000,
  parameter int DEAD_CYC   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] num,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int SLOT_W = $clog2(DIV_CNT);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIV_CNT - 1);
  localparam logic [SLOT_W-1:0] DEAD_START = SLOT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]  IDX_TOP    = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]              slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]     num_snap_q;
  logic [NUM_DIGITS-1:0]          dp_snap_q, blank_snap_q;
  logic                           lz_snap_q;

  logic [NUM_DIGITS-1:0]          an_q, an_d;
  logic [6:0]                     seg_q, seg_d;
  logic                           dp_q, dp_d;
  logic                           frame_tick_q;

  logic                           frame_start;
  logic [NUM_DIGITS-1:0]          hidden;
  logic                           upper_zero;
  logic [6:0]                     cur_seg;
  logic                           lit;

  assign frame_start = (slot_cnt_q == '0) && (idx_q == IDX_TOP);

  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      idx_d      = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero only
  // while every digit above it (and itself) is zero. Digit 0 always shows.
  always_comb begin
    upper_zero = 1'b1;
    hidden     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (num_snap_q[i] == 4'h0);
      hidden[i]  = blank_snap_q[i] | (lz_snap_q & upper_zero & (i != 0));
    end
  end

  ssd_hex_decoder u_dec (
    .nib_i (num_snap_q[idx_q]),
    .seg_o (cur_seg)
  );

  assign lit = (slot_cnt_q >= DEAD_START) && !hidden[idx_q];

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = cur_seg;
      dp_d  = ~dp_snap_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      idx_q        <= IDX_TOP;
      num_snap_q   <= '0;
      dp_snap_q    <= '0;
      blank_snap_q <= '0;
      lz_snap_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      if (frame_start) begin
        num_snap_q   <= num;
        dp_snap_q    <= dp_in;
        blank_snap_q <= blank;
        lz_snap_q    <= lz_en;
      end
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_start;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
